// File: rtl/rx_chain_sequencer.sv
//==============================================================================
// rx_chain_sequencer: sequences samples -> PAM4 decoder -> gray decoder -> words
// Optional PRBS7 bit checker under RX_PRBS_CHECK_EN.   Rev 1.0
//==============================================================================
`default_nettype none

module rx_chain_sequencer #(
   parameter int WORD_W      = 32,
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  frame_len,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [LEN_W-1:0]  sym_count,
   input  logic [7:0]        sample_in,
   input  logic              sample_in_valid,
   output logic              sample_in_ready,
   output logic [7:0]        level_out,
   output logic              level_out_valid,
   input  logic [1:0]        symbol_in,
   input  logic              symbol_in_valid,
   output logic [1:0]        gray_sym_out,
   output logic              gray_sym_out_valid,
   input  logic              bit_in,
   input  logic              bit_in_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_out_valid,
   input  logic              word_out_ready
`ifdef RX_PRBS_CHECK_EN
   ,
   output logic [15:0]       err_count
`endif
);

   localparam int BC_W = $clog2(WORD_W + 1);
   localparam int TM_W = $clog2(TIMEOUT_CYC);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);
   localparam logic [BC_W-1:0] BC_ROOM = BC_W'(WORD_W - 2);
   localparam logic [TM_W-1:0] TM_MAX  = TM_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_SYM  = 3'd2,
      WAIT_BITS = 3'd3,
      FLUSH     = 3'd4,
      DONE      = 3'd5,
      ERR       = 3'd6
   } state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  sym_count_inc;
   logic [BC_W-1:0]   bitcnt;
   logic [TM_W-1:0]   timer;
   logic              second_bit;
   logic              accept_start, take_sample, take_sym, take_bit, last_bit, tmo, align;

   assign sym_count_inc   = sym_count + LEN_W'(1);
   assign word_out_valid  = (bitcnt == BC_FULL);
   assign sample_in_ready = (state == ISSUE) && (bitcnt <= BC_ROOM) && !word_out_valid;
   assign busy            = (state == ISSUE) || (state == WAIT_SYM) ||
                            (state == WAIT_BITS) || (state == FLUSH);
   assign done            = (state == DONE);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      take_sample  = 1'b0;
      take_sym     = 1'b0;
      take_bit     = 1'b0;
      last_bit     = 1'b0;
      tmo          = 1'b0;
      align        = 1'b0;
      case (state)
         IDLE: begin
            if (start && (frame_len != '0)) begin
               accept_start = 1'b1;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            if (sample_in_valid && sample_in_ready) begin
               take_sample = 1'b1;
               state_nxt   = WAIT_SYM;
            end
         end
         WAIT_SYM: begin
            if (symbol_in_valid) begin
               take_sym  = 1'b1;
               state_nxt = WAIT_BITS;
            end else if (timer == TM_MAX) begin
               tmo       = 1'b1;
               state_nxt = ERR;
            end
         end
         WAIT_BITS: begin
            if (bit_in_valid) begin
               take_bit = 1'b1;
               if (second_bit) begin
                  last_bit  = 1'b1;
                  state_nxt = (sym_count_inc == len) ? FLUSH : ISSUE;
               end
            end else if (timer == TM_MAX) begin
               tmo       = 1'b1;
               state_nxt = ERR;
            end
         end
         FLUSH: begin
            // A partial word is left-aligned once, which also marks it full.
            if (bitcnt == '0)         state_nxt = DONE;
            else if (!word_out_valid) align     = 1'b1;
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         len                <= '0;
         sym_count          <= '0;
         bitcnt             <= '0;
         word_out           <= '0;
         timer              <= '0;
         second_bit         <= 1'b0;
         timeout_err        <= 1'b0;
         level_out          <= '0;
         level_out_valid    <= 1'b0;
         gray_sym_out       <= '0;
         gray_sym_out_valid <= 1'b0;
      end else begin
         level_out_valid    <= take_sample;
         gray_sym_out_valid <= take_sym;
         if (take_sample) level_out    <= sample_in;
         if (take_sym)    gray_sym_out <= symbol_in;

         if (take_sample || take_sym || take_bit || tmo)
            timer <= '0;
         else if ((state == WAIT_SYM) || (state == WAIT_BITS))
            timer <= timer + TM_W'(1);

         if (accept_start || tmo) second_bit <= 1'b0;
         else if (take_bit)       second_bit <= ~second_bit;

         if (accept_start) begin
            len         <= frame_len;
            sym_count   <= '0;
            timeout_err <= 1'b0;
         end else if (last_bit) begin
            sym_count   <= sym_count_inc;
         end else if (tmo) begin
            timeout_err <= 1'b1;
         end

         if (accept_start || tmo) begin
            bitcnt   <= '0;
            word_out <= '0;
         end else if (take_bit) begin
            word_out <= {word_out[WORD_W-2:0], bit_in};
            bitcnt   <= bitcnt + BC_W'(1);
         end else if (align) begin
            word_out <= word_out << (BC_FULL - bitcnt);
            bitcnt   <= BC_FULL;
         end else if (word_out_valid && word_out_ready) begin
            bitcnt   <= '0;
         end
      end
   end

`ifdef RX_PRBS_CHECK_EN
   logic [6:0] prbs;
   logic       prbs_bit;

   assign prbs_bit = prbs[6] ^ prbs[5];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         prbs      <= 7'h7F;
         err_count <= '0;
      end else if (accept_start) begin
         prbs      <= 7'h7F;
         err_count <= '0;
      end else if (take_bit) begin
         prbs <= {prbs[5:0], prbs_bit};
         if ((bit_in != prbs_bit) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_chain_sequencer.sv
//==============================================================================
// tb_rx_chain_sequencer: directed bench with stub PAM4/gray decoders (latency 3).
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_rx_chain_sequencer;

   localparam int WORD_W = 8;
   localparam int LEN_W  = 16;
   localparam int TMO    = 16;
   localparam int LAT    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  frame_len = '0;
   logic              busy, done, timeout_err;
   logic [LEN_W-1:0]  sym_count;
   logic [7:0]        sample_in = '0;
   logic              sample_in_valid = 1'b1;
   logic              sample_in_ready;
   logic [7:0]        level_out;
   logic              level_out_valid;
   logic [1:0]        symbol_in = '0;
   logic              symbol_in_valid = 1'b0;
   logic [1:0]        gray_sym_out;
   logic              gray_sym_out_valid;
   logic              bit_in = 1'b0;
   logic              bit_in_valid = 1'b0;
   logic [WORD_W-1:0] word_out;
   logic              word_out_valid;
   logic              word_out_ready = 1'b1;
`ifdef RX_PRBS_CHECK_EN
   logic [15:0]       err_count;
`endif

   int          total = 0;
   int          bad = 0;
   logic [7:0]  samp [64];
   int          src_idx = 0;
   logic [7:0]  got_q [$];
   int          done_cnt = 0;
   logic        pam_mute = 1'b0;

   rx_chain_sequencer #(.WORD_W(WORD_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .frame_len(frame_len),
      .busy(busy), .done(done), .timeout_err(timeout_err), .sym_count(sym_count),
      .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(sample_in_ready),
      .level_out(level_out), .level_out_valid(level_out_valid),
      .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid),
      .gray_sym_out(gray_sym_out), .gray_sym_out_valid(gray_sym_out_valid),
      .bit_in(bit_in), .bit_in_valid(bit_in_valid),
      .word_out(word_out), .word_out_valid(word_out_valid), .word_out_ready(word_out_ready)
`ifdef RX_PRBS_CHECK_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample source: advance to the next sample after each issued level.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (level_out_valid) src_idx++;
         sample_in = samp[src_idx];
      end
   end

   // PAM4 stub: symbol is the top two bits of the level.
   initial begin
      logic [1:0] s;
      forever begin
         @(posedge clk); #1;
         if (level_out_valid && !pam_mute) begin
            s = level_out[7:6];
            repeat (LAT - 1) @(posedge clk);
            #1;
            symbol_in = s; symbol_in_valid = 1'b1;
            @(posedge clk); #1;
            symbol_in_valid = 1'b0;
         end
      end
   end

   // Gray stub: emits the symbol bits MSB first on consecutive cycles.
   initial begin
      logic [1:0] s;
      forever begin
         @(posedge clk); #1;
         if (gray_sym_out_valid) begin
            s = gray_sym_out;
            repeat (LAT - 1) @(posedge clk);
            #1;
            bit_in = s[1]; bit_in_valid = 1'b1;
            @(posedge clk); #1;
            bit_in = s[0];
            @(posedge clk); #1;
            bit_in_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (word_out_valid && word_out_ready) got_q.push_back(word_out);
      if (done) done_cnt++;
   end

   task automatic kick(input int len);
      @(posedge clk); #1;
      src_idx = 0; sample_in = samp[0];
      got_q.delete(); done_cnt = 0;
      start = 1'b1; frame_len = LEN_W'(len);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      logic [6:0] p;
      logic       b;
      logic [63:0] pbits;
      int          n;
      foreach (samp[i]) samp[i] = 8'h20;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_terr",  32'(timeout_err), 32'd0);
      check("rst_cnt",   32'(sym_count), 32'd0);
      check("rst_wvld",  32'(word_out_valid), 32'd0);
      check("rst_srdy",  32'(sample_in_ready), 32'd0);
      rst_n = 1'b1;

      // Basic frame: bits 00,01,11,10
      samp[0] = 8'h20; samp[1] = 8'h60; samp[2] = 8'hE0; samp[3] = 8'hA0;
      kick(4);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done", 400);
      @(posedge clk); #1;
      check("t1_nw",   32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("t1_word", 32'(got_q[0]), 32'h1E);
      check("t1_cnt",  32'(sym_count), 32'd4);
      check("t1_busy0", 32'(busy), 32'd0);
      check("t1_pulse", 32'(done_cnt), 32'd1);

      // Partial word zero-padded
      samp[0] = 8'hE0; samp[1] = 8'hE0; samp[2] = 8'hE0;
      kick(3);
      wait_done("t2_done", 400);
      check("t2_nw",   32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("t2_word", 32'(got_q[0]), 32'hFC);
      check("t2_cnt",  32'(sym_count), 32'd3);

      // Backpressure: first word 1B stalls the issue gate
      samp[0] = 8'h20; samp[1] = 8'h60; samp[2] = 8'hA0; samp[3] = 8'hE0;
      samp[4] = 8'hE0; samp[5] = 8'hA0; samp[6] = 8'h60; samp[7] = 8'h20;
      word_out_ready = 1'b0;
      kick(8);
      n = 0;
      while (sym_count != 16'd4 && n < 400) begin @(posedge clk); #1; n++; end
      check("t3_reach4", 32'(sym_count), 32'd4);
      b = 1'b0;
      repeat (20) begin @(posedge clk); #1; b = b | sample_in_ready; end
      check("t3_srdy",  32'(b), 32'd0);
      check("t3_wvld",  32'(word_out_valid), 32'd1);
      check("t3_whold", 32'(word_out), 32'h1B);
      check("t3_cnt",   32'(sym_count), 32'd4);
      word_out_ready = 1'b1;
      wait_done("t3_done", 400);
      check("t3_nw", 32'(got_q.size()), 32'd2);
      if (got_q.size() > 1) begin
         check("t3_w0", 32'(got_q[0]), 32'h1B);
         check("t3_w1", 32'(got_q[1]), 32'hE4);
      end

      // Timeout: PAM4 stub silent
      pam_mute = 1'b1;
      kick(2);
      n = 0;
      while (!level_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("t4_lvld", 32'(level_out_valid), 32'd1);
      repeat (TMO - 1) @(posedge clk);
      #1;
      check("t4_early", 32'(timeout_err), 32'd0);
      @(posedge clk); #1;
      check("t4_terr",  32'(timeout_err), 32'd1);
      check("t4_busy",  32'(busy), 32'd0);
      check("t4_wvld",  32'(word_out_valid), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("t4_nodone", 32'(done_cnt), 32'd0);
      check("t4_sticky", 32'(timeout_err), 32'd1);
      pam_mute = 1'b0;
      repeat (10) @(posedge clk);

      // Reset during WAIT_BITS of the second symbol
      samp[0] = 8'hE0; samp[1] = 8'h60; samp[2] = 8'hE0; samp[3] = 8'hA0;
      kick(4);
      check("t5_terrclr", 32'(timeout_err), 32'd0);
      n = 0;
      while (sym_count != 16'd1 && n < 200) begin @(posedge clk); #1; n++; end
      n = 0;
      while (!gray_sym_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("t5_gvld",  32'(gray_sym_out_valid), 32'd1);
      check("t5_wpre",  32'(word_out), 32'h03);
      rst_n = 1'b0;
      #1;
      check("t5_gvld0", 32'(gray_sym_out_valid), 32'd0);
      check("t5_word0", 32'(word_out), 32'd0);
      check("t5_cnt0",  32'(sym_count), 32'd0);
      check("t5_busy0", 32'(busy), 32'd0);
      check("t5_lvl0",  32'(level_out), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      samp[0] = 8'h20; samp[1] = 8'h60; samp[2] = 8'hE0; samp[3] = 8'hA0;
      kick(4);
      wait_done("t5_done", 400);
      check("t5_nw", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("t5_word", 32'(got_q[0]), 32'h1E);

`ifdef RX_PRBS_CHECK_EN
      p = 7'h7F;
      for (int i = 0; i < 64; i++) begin
         b = p[6] ^ p[5];
         p = {p[5:0], b};
         pbits[63 - i] = b;
      end
      for (int i = 0; i < 32; i++) samp[i] = {pbits[63 - 2*i], pbits[62 - 2*i], 6'h00};
      kick(32);
      wait_done("t6_done", 2000);
      check("t6_err0", 32'(err_count), 32'd0);
      check("t6_nw",   32'(got_q.size()), 32'd8);
      pbits[63 - 5]  = ~pbits[63 - 5];
      pbits[63 - 20] = ~pbits[63 - 20];
      pbits[63 - 41] = ~pbits[63 - 41];
      for (int i = 0; i < 32; i++) samp[i] = {pbits[63 - 2*i], pbits[62 - 2*i], 6'h00};
      kick(32);
      wait_done("t6b_done", 2000);
      check("t6_err3", 32'(err_count), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
